// File: rtl/synth_pkg.sv
// Shared constants for the voice mixer/decimator: voice count, gain and
// per-cycle term widths, and the dither LFSR polynomial, seed and step function.
package synth_pkg;

  localparam int NUM_VOICES = 5;
  localparam int VEL_W      = 7;
  localparam int TERM_W     = 10;

  // x^16 + x^14 + x^13 + x^11 + 1, expressed as tap mask on bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // One Fibonacci step: shift left, feed back XOR of the tapped bits
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/voice_mix_decim_mix_sat.sv
// mix_sat: combinational output stage. Adds the (optional) dither to the
// window total, shifts down by SHIFT and saturates to an unsigned OUT_W sample.
// WIN_W must exceed OUT_W so the overflow bits exist.
module mix_sat
  import synth_pkg::*;
#(
  parameter int WIN_W = 15,
  parameter int OUT_W = 8,
  parameter int SHIFT = 6
) (
  input  logic [WIN_W-1:0] i_win,
  input  logic [WIN_W-1:0] i_dither,
  output logic [OUT_W-1:0] o_sample,
  output logic             o_clip
);

  logic [WIN_W-1:0] w_sum;
  logic [WIN_W-1:0] w_v;

  // Dither add, scale down, then clamp anything above the output range
  always_comb begin
    w_sum = i_win + i_dither;
    w_v   = w_sum >> SHIFT;
    if (|w_v[WIN_W-1:OUT_W]) begin
      o_sample = {OUT_W{1'b1}};
      o_clip   = 1'b1;
    end else begin
      o_sample = w_v[OUT_W-1:0];
      o_clip   = 1'b0;
    end
  end

endmodule

// File: rtl/voice_mix_decim.sv
// voice_mix_decim: weights the five one-bit voices by gains latched once per
// window, integrates over 2^DECIM_LOG2 cycles and emits one saturated sample
// per window with a single-cycle valid strobe.
// Optional build macro VOICE_MIX_DITHER_EN adds LFSR dither ahead of the
// truncating shift; without it the output is plain truncation.
module voice_mix_decim
  import synth_pkg::*;
#(
  parameter int DECIM_LOG2 = 4,
  parameter int OUT_W      = 8,
  parameter int SHIFT      = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_VOICES-1:0]       voice_in,
  input  logic [NUM_VOICES*VEL_W-1:0] voice_gain,
  input  logic                        mute,
  output logic [OUT_W-1:0]            sample,
  output logic                        sample_valid,
  output logic                        clip
);

  localparam int ACC_W = TERM_W + DECIM_LOG2;
  localparam int WIN_W = ACC_W + 1;

  logic [DECIM_LOG2-1:0]       r_cnt;
  logic [NUM_VOICES*VEL_W-1:0] r_gain_q;
  logic [ACC_W-1:0]            r_acc;

  logic                        w_first;
  logic                        w_last;
  logic [NUM_VOICES*VEL_W-1:0] w_gain;
  logic [TERM_W-1:0]           w_term;
  logic [ACC_W-1:0]            w_win;
  logic [WIN_W-1:0]            w_dither;
  logic [OUT_W-1:0]            w_sat_sample;
  logic                        w_sat_clip;

  // Window position, gain selection (new gains apply on the latch cycle) and weighted sum
  always_comb begin
    w_first = (r_cnt == {DECIM_LOG2{1'b0}});
    w_last  = (r_cnt == {DECIM_LOG2{1'b1}});
    if (w_first) begin
      w_gain = voice_gain;
    end else begin
      w_gain = r_gain_q;
    end
    w_term = {TERM_W{1'b0}};
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (voice_in[i]) begin
        w_term = w_term + {{(TERM_W-VEL_W){1'b0}}, w_gain[i*VEL_W +: VEL_W]};
      end else begin
        w_term = w_term;
      end
    end
    w_win = r_acc + {{(ACC_W-TERM_W){1'b0}}, w_term};
  end

`ifdef VOICE_MIX_DITHER_EN
  localparam int DW = (SHIFT < 16) ? SHIFT : 16;
  logic [15:0] r_lfsr;

  // Dither source: steps once per window, on the window's final cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= LFSR_SEED;
    end else if (w_last) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end else begin
      r_lfsr <= r_lfsr;
    end
  end

  assign w_dither = WIN_W'(r_lfsr[DW-1:0]);
`else
  assign w_dither = {WIN_W{1'b0}};
`endif

  mix_sat #(
    .WIN_W (WIN_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_mix_sat (
    .i_win    ({1'b0, w_win}),
    .i_dither (w_dither),
    .o_sample (w_sat_sample),
    .o_clip   (w_sat_clip)
  );

  // Window counter, once-per-window gain latch and integrating accumulator
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= {DECIM_LOG2{1'b0}};
      r_gain_q <= {(NUM_VOICES*VEL_W){1'b0}};
      r_acc    <= {ACC_W{1'b0}};
    end else begin
      r_cnt <= r_cnt + DECIM_LOG2'(1);
      if (w_first) begin
        r_gain_q <= voice_gain;
      end else begin
        r_gain_q <= r_gain_q;
      end
      if (w_last) begin
        r_acc <= {ACC_W{1'b0}};
      end else begin
        r_acc <= w_win;
      end
    end
  end

  // Output sample, clip flag and strobe, updated only at the end of each window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample       <= {OUT_W{1'b0}};
      clip         <= 1'b0;
      sample_valid <= 1'b0;
    end else if (w_last) begin
      sample_valid <= 1'b1;
      if (mute) begin
        sample <= {OUT_W{1'b0}};
        clip   <= 1'b0;
      end else begin
        sample <= w_sat_sample;
        clip   <= w_sat_clip;
      end
    end else begin
      sample_valid <= 1'b0;
      sample       <= sample;
      clip         <= clip;
    end
  end

endmodule

// File: tb/tb_voice_mix_decim.sv
// Directed bench for voice_mix_decim in the default (no dither) build.
// Two instances share stimulus: SHIFT=6 (default) and SHIFT=5 (clip cases).
module tb_voice_mix_decim;

  logic        clk;
  logic        rst;
  logic [4:0]  voice_in;
  logic [34:0] voice_gain;
  logic        mute;

  logic [7:0]  sample_a, sample_b;
  logic        valid_a, valid_b;
  logic        clip_a, clip_b;

  int n_checks;
  int n_pass;
  int n;

  voice_mix_decim #(.DECIM_LOG2(4), .OUT_W(8), .SHIFT(6)) u_dut_a (
    .clk          (clk),
    .rst          (rst),
    .voice_in     (voice_in),
    .voice_gain   (voice_gain),
    .mute         (mute),
    .sample       (sample_a),
    .sample_valid (valid_a),
    .clip         (clip_a)
  );

  voice_mix_decim #(.DECIM_LOG2(4), .OUT_W(8), .SHIFT(5)) u_dut_b (
    .clk          (clk),
    .rst          (rst),
    .voice_in     (voice_in),
    .voice_gain   (voice_gain),
    .mute         (mute),
    .sample       (sample_b),
    .sample_valid (valid_b),
    .clip         (clip_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edges counted until the strobe is seen; leaves time in the new window's cnt==0 cycle
  task automatic wait_strobe(output int edges);
    edges = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      edges++;
      if (valid_a) break;
    end
    if (!valid_a) check("strobe_timeout", 0, 1);
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    rst        = 1'b0;
    voice_in   = 5'b00000;
    voice_gain = 35'd0;
    mute       = 1'b0;

    #2;
    repeat (3) step();
    check("rst_sample", sample_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_clip", clip_a, 0);

    // Silence with arbitrary gains
    voice_gain = {5{7'd99}};
    @(negedge clk);
    rst = 1'b1;
    wait_strobe(n);
    check("first_strobe_edges", n, 16);
    check("silent_sample", sample_a, 0);
    check("silent_clip", clip_a, 0);
    step();
    check("strobe_one_cycle", valid_a, 0);
    wait_strobe(n);
    check("strobe_period", n, 15);
    check("silent_sample2", sample_a, 0);

    // Single voice, gain 64: 1024 per window
    voice_in   = 5'b00001;
    voice_gain = {28'd0, 7'd64};
    wait_strobe(n);
    check("v1_g64_edges", n, 16);
    check("v1_g64_a", sample_a, 16);
    check("v1_g64_clip_a", clip_a, 0);
    check("v1_g64_b", sample_b, 32);

    // Full scale: 10160 per window
    voice_in   = 5'b11111;
    voice_gain = {5{7'd127}};
    wait_strobe(n);
    check("full_a", sample_a, 158);
    check("full_clip_a", clip_a, 0);
    check("full_b_sat", sample_b, 255);
    check("full_clip_b", clip_b, 1);

    // Mid-window gain change applies from the next window only
    voice_in   = 5'b00001;
    voice_gain = {28'd0, 7'd64};
    wait_strobe(n);
    check("pre_zip_a", sample_a, 16);
    repeat (8) step();
    voice_gain = {28'd0, 7'd127};
    wait_strobe(n);
    check("zip_hold_a", sample_a, 16);
    wait_strobe(n);
    check("zip_next_a", sample_a, 31);
    check("zip_next_b", sample_b, 63);

    // Gain change on the last cycle of a window does not reach that sample
    voice_in   = 5'b11111;
    voice_gain = {5{7'd127}};
    repeat (15) step();
    voice_gain = 35'd0;
    wait_strobe(n);
    check("last_gain_edges", n, 1);
    check("last_gain_a", sample_a, 158);
    wait_strobe(n);
    check("last_gain_next_a", sample_a, 0);
    check("last_gain_next_clip_b", clip_b, 0);

    // Mute forces zero; release mid-window gives full value
    voice_gain = {5{7'd127}};
    mute       = 1'b1;
    wait_strobe(n);
    check("mute_a", sample_a, 0);
    check("mute_b", sample_b, 0);
    check("mute_clip_b", clip_b, 0);
    repeat (5) step();
    mute = 1'b0;
    wait_strobe(n);
    check("unmute_a", sample_a, 158);
    check("unmute_b", sample_b, 255);
    check("unmute_clip_b", clip_b, 1);

    // Asynchronous reset at cnt=10 of a busy window
    repeat (10) step();
    #3;
    rst = 1'b0;
    #1;
    check("mid_rst_sample_a", sample_a, 0);
    check("mid_rst_valid_a", valid_a, 0);
    check("mid_rst_sample_b", sample_b, 0);
    check("mid_rst_clip_b", clip_b, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    wait_strobe(n);
    check("post_rst_edges", n, 16);
    check("post_rst_a", sample_a, 158);
    check("post_rst_b", sample_b, 255);

    // Mute taken on the window's last cycle silences that sample
    repeat (15) step();
    mute = 1'b1;
    wait_strobe(n);
    mute = 1'b0;
    check("mute_last_a", sample_a, 0);
    check("mute_last_clip_b", clip_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
